dac8_wave_player: RTL and testbench



---
 rtl/dac8_wp_pkg.sv | 25 ++
 rtl/dac8_wp_fifo.sv | 48 ++++
 rtl/dac8_wave_player.sv | 145 ++++++++++++++
 tb/tb_dac8_wave_player.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac8_wp_pkg.sv
// dac8_wave_player shared definitions: register map, bit positions, reset code.
// Interrupt logic is built only with DAC8_WP_IRQ_EN defined.
package dac8_wp_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_IM       = 3'd4;
  localparam logic [2:0] REG_RIS      = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam int ST_EMPTY    = 8;
  localparam int ST_FULL     = 9;
  localparam int ST_UNDERRUN = 10;
  localparam int ST_OVERFLOW = 11;

  localparam int IRQ_LWM     = 0;
  localparam int IRQ_UNDER   = 1;

  localparam logic [7:0] DAC_RESET_CODE = 8'h80;

endpackage

// File: rtl/dac8_wp_fifo.sv
// Sample FIFO for dac8_wave_player; extra pointer bit separates full from empty.
// Push when full and pop when empty are ignored.
module dac8_wp_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign level   = wptr - rptr;
  assign empty   = level == '0;
  assign full    = level == FULL_LVL;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dac8_wave_player.sv
// Wishbone-fed FIFO waveform player driving the 8-bit DAC at a divided rate.
// Define DAC8_WP_IRQ_EN to build the IM / RIS-ICR registers and irq output.
module dac8_wave_player
  import dac8_wp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LWM   = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [7:0]  dac_code,
  output logic        dac_strobe,
  output logic        irq
);

  logic        acc, wr, rd;
  logic [2:0]  idx;
  logic        en, underrun, overflow;
  logic [15:0] prescale, cnt;
  logic        tick, restart, flush, push, pop, st_clr;
  logic [7:0]  head;
  logic [AW:0] level;
  logic        full, empty;
  logic [31:0] rdata;
  logic [1:0]  ris, im;
  logic        unused_bits;

  assign unused_bits = ^{adr_i[31:5], adr_i[1:0], dat_i[31:16], sel_i[3:2]};

  assign acc     = cyc_i & stb_i & ~ack_o;
  assign wr      = acc & we_i;
  assign rd      = acc & ~we_i;
  assign idx     = adr_i[4:2];
  assign flush   = wr & (idx == REG_CTRL) & sel_i[0] & dat_i[CTRL_FLUSH];
  assign restart = flush | (wr & (idx == REG_PRESCALE));
  assign tick    = en & (cnt == prescale) & ~restart;
  assign push    = wr & (idx == REG_DATA) & sel_i[0];
  assign pop     = tick & ~empty;
  assign st_clr  = wr & (idx == REG_STATUS) & sel_i[1];

  dac8_wp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (dat_i[7:0]),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      en       <= 1'b0;
      prescale <= '0;
      cnt      <= '0;
    end else begin
      ack_o <= acc;
      dat_o <= rd ? rdata : '0;
      if (wr && idx == REG_CTRL && sel_i[0])
        en <= dat_i[CTRL_EN];
      if (wr && idx == REG_PRESCALE) begin
        if (sel_i[0]) prescale[7:0]  <= dat_i[7:0];
        if (sel_i[1]) prescale[15:8] <= dat_i[15:8];
      end
      if (!en || restart || cnt == prescale)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
    end
  end

  // Stickies: a new event in the same cycle as a W1C wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dac_code   <= DAC_RESET_CODE;
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dac_strobe <= pop;
      if (pop) dac_code <= head;
      underrun <= (underrun & ~(st_clr & dat_i[ST_UNDERRUN])) | (tick & empty);
      overflow <= (overflow & ~(st_clr & dat_i[ST_OVERFLOW])) | (push & full);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      idx == REG_CTRL:     rdata[CTRL_EN] = en;
      idx == REG_PRESCALE: rdata[15:0] = prescale;
      idx == REG_STATUS: begin
        rdata[AW:0]        = level;
        rdata[ST_EMPTY]    = empty;
        rdata[ST_FULL]     = full;
        rdata[ST_UNDERRUN] = underrun;
        rdata[ST_OVERFLOW] = overflow;
      end
      idx == REG_IM:       rdata[1:0] = im;
      idx == REG_RIS:      rdata[1:0] = ris;
      default: ;
    endcase
  end

`ifdef DAC8_WP_IRQ_EN
  logic lw, lw_q;

  assign lw = int'(level) <= LWM;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      im   <= '0;
      ris  <= '0;
      lw_q <= 1'b1;
    end else begin
      lw_q <= lw;
      if (wr && idx == REG_IM && sel_i[0])
        im <= dat_i[1:0];
      ris <= (ris & ~({2{wr && idx == REG_RIS && sel_i[0]}} & dat_i[1:0]))
           | {tick & empty, lw & ~lw_q & en};
    end
  end

  assign irq = |(ris & im);
`else
  assign im  = '0;
  assign ris = '0;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dac8_wave_player.sv
// Bench for dac8_wave_player: directed steps plus random bus traffic,
// compared every cycle against a queue-based reference model.
module tb_dac8_wave_player;

  localparam int DEPTH = 16;
  localparam int LWM   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = 4'hF;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [7:0]  dac_code;
  logic        dac_strobe;
  logic        irq;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  dac8_wave_player #(.DEPTH(DEPTH), .LWM(LWM)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .adr_i      (adr),
    .dat_i      (dat),
    .dat_o      (dat_o),
    .sel_i      (sel),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .we_i       (we),
    .ack_o      (ack_o),
    .dac_code   (dac_code),
    .dac_strobe (dac_strobe),
    .irq        (irq)
  );

  // Reference model state
  logic [7:0]  q[$];
  bit          m_en, m_und, m_ovf, m_lwp, m_ack, m_strobe, m_irq;
  logic [15:0] m_pre;
  int          m_cnt;
  logic [7:0]  m_code;
  logic [31:0] m_dat;
  logic [1:0]  m_ris, m_im;

  function automatic logic [31:0] reg_read(input logic [2:0] i);
    logic [31:0] r;
    r = '0;
    case (i)
      3'd1: r[0] = m_en;
      3'd2: r[15:0] = m_pre;
      3'd3: begin
        r[7:0] = 8'(q.size());
        r[8]   = q.size() == 0;
        r[9]   = q.size() == DEPTH;
        r[10]  = m_und;
        r[11]  = m_ovf;
      end
`ifdef DAC8_WP_IRQ_EN
      3'd4: r[1:0] = m_im;
      3'd5: r[1:0] = m_ris;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    bit acc, wr, fl, rs, tk, lw_now;
    logic [2:0] i;
    int lvl;
    if (rst) begin
      q.delete();
      m_en = 0; m_pre = '0; m_cnt = 0; m_code = 8'h80;
      m_strobe = 0; m_ack = 0; m_dat = '0; m_und = 0; m_ovf = 0;
      m_ris = '0; m_im = '0; m_lwp = 1; m_irq = 0;
    end else begin
      acc = cyc && stb && !m_ack;
      wr  = acc && we;
      i   = adr[4:2];
      fl  = wr && i == 3'd1 && dat[1];
      rs  = fl || (wr && i == 3'd2);
      tk  = m_en && m_cnt == int'(m_pre) && !rs;
      lvl = q.size();
      m_dat = (acc && !we) ? reg_read(i) : '0;
      m_ack = acc;
      m_strobe = 0;
`ifdef DAC8_WP_IRQ_EN
      lw_now = lvl <= LWM;
      if (wr && i == 3'd5) m_ris = m_ris & ~dat[1:0];
      if (lw_now && !m_lwp && m_en) m_ris[0] = 1'b1;
      if (tk && lvl == 0) m_ris[1] = 1'b1;
      m_lwp = lw_now;
      if (wr && i == 3'd4) m_im = dat[1:0];
`endif
      if (wr && i == 3'd3) begin
        if (dat[10]) m_und = 0;
        if (dat[11]) m_ovf = 0;
      end
      if (tk) begin
        if (lvl == 0) m_und = 1;
        else begin
          m_code = q.pop_front();
          m_strobe = 1;
        end
      end
      if (wr && i == 3'd0) begin
        if (lvl == DEPTH) m_ovf = 1;
        else q.push_back(dat[7:0]);
      end
      if (fl) q.delete();
      if (!m_en || rs || m_cnt == int'(m_pre)) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      if (wr && i == 3'd1) m_en = dat[0];
      if (wr && i == 3'd2) m_pre = dat[15:0];
      m_irq = |(m_ris & m_im);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_checks += 5;
      assert (dac_code === m_code) else begin
        n_err++; $error("FAIL dac_code: got %h expected %h", dac_code, m_code);
      end
      assert (dac_strobe === m_strobe) else begin
        n_err++; $error("FAIL dac_strobe: got %b expected %b", dac_strobe, m_strobe);
      end
      assert (ack_o === m_ack) else begin
        n_err++; $error("FAIL ack_o: got %b expected %b", ack_o, m_ack);
      end
      assert (dat_o === m_dat) else begin
        n_err++; $error("FAIL dat_o: got %h expected %h", dat_o, m_dat);
      end
      assert (irq === m_irq) else begin
        n_err++; $error("FAIL irq: got %b expected %b", irq, m_irq);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++; $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] i, input logic [31:0] d);
    cyc = 1; stb = 1; we = 1; adr = {27'b0, i, 2'b0}; dat = d;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; dat = '0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [2:0] i, output logic [31:0] d);
    cyc = 1; stb = 1; we = 0; adr = {27'b0, i, 2'b0};
    @(posedge clk); #1;
    d = dat_o;
    cyc = 0; stb = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  got[$];
    time         t[$];
    logic [7:0]  smp[9];
    logic [7:0]  saved;
    bit          irq_seen;
    int          r;

    // Reset
    @(posedge clk); #1;
    chk_on = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst_code", 32'(dac_code), 32'h80);
    check("rst_ack", 32'(ack_o), 32'h0);
    wb_read(3'd3, d);
    check("rst_status", d, 32'h100);

    // Basic playback at PRESCALE=3
    wb_write(3'd0, 32'h11);
    wb_write(3'd0, 32'h22);
    wb_write(3'd0, 32'h33);
    wb_write(3'd2, 32'd3);
    wb_write(3'd1, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dac_strobe) begin
        got.push_back(dac_code);
        t.push_back($time);
      end
    end
    @(posedge clk); #1;
    check("play_count", 32'(got.size()), 32'd3);
    check("play_0", 32'(got[0]), 32'h11);
    check("play_1", 32'(got[1]), 32'h22);
    check("play_2", 32'(got[2]), 32'h33);
    check("play_gap01", 32'(t[1] - t[0]), 32'd40);
    check("play_gap12", 32'(t[2] - t[1]), 32'd40);
    check("play_hold", 32'(dac_code), 32'h33);
    wb_read(3'd3, d);
    check("play_underrun", d, 32'h500);

    // Overflow
    wb_write(3'd1, 32'd0);
    wb_write(3'd3, 32'hC00);
    for (int k = 0; k < 17; k++) wb_write(3'd0, 32'(k + 8'h40));
    wb_read(3'd3, d);
    check("ovf_status", d, 32'hA10);
    wb_write(3'd3, 32'h800);
    wb_read(3'd3, d);
    check("ovf_w1c", d, 32'h210);

    // Flush, then PRESCALE=0 pacing
    wb_write(3'd1, 32'd2);
    wb_read(3'd3, d);
    check("flush_status", d, 32'h100);
    wb_write(3'd2, 32'd0);
    wb_write(3'd1, 32'd1);
    for (int k = 0; k < 5; k++) begin
      wb_write(3'd0, $urandom);
      wb_read(3'd3, d);
      check("pace_status", d, 32'h500);
    end

    // Low-water interrupt
    wb_write(3'd1, 32'd0);
    wb_write(3'd1, 32'd2);
    wb_write(3'd3, 32'hC00);
    wb_write(3'd5, 32'd3);
    wb_write(3'd4, 32'd1);
    wb_write(3'd2, 32'd7);
    for (int k = 0; k < 8; k++) wb_write(3'd0, $urandom);
    wb_write(3'd1, 32'd1);
    irq_seen = 0;
    for (int k = 0; k < 200 && !irq_seen; k++) begin
      @(negedge clk);
      irq_seen = irq;
    end
    @(posedge clk); #1;
`ifdef DAC8_WP_IRQ_EN
    check("irq_rise", 32'(irq_seen), 32'd1);
    wb_read(3'd3, d);
    check("irq_level", 32'(d[7:0]), 32'd4);
    wb_write(3'd5, 32'd1);
    check("irq_clear", 32'(irq), 32'd0);
`else
    check("irq_tied", 32'(irq_seen), 32'd0);
    wb_read(3'd4, d);
    check("im_reads0", d, 32'd0);
`endif

    // Flush mid-playback with level 5
    wb_write(3'd1, 32'd0);
    wb_write(3'd1, 32'd2);
    wb_write(3'd3, 32'hC00);
    for (int k = 0; k < 9; k++) begin
      smp[k] = 8'($urandom);
      wb_write(3'd0, 32'(smp[k]));
    end
    wb_write(3'd2, 32'd3);
    wb_write(3'd1, 32'd1);
    repeat (16) @(posedge clk);
    #1;
    saved = dac_code;
    check("mid_code", 32'(saved), 32'(smp[3]));
    wb_write(3'd1, 32'd3);
    check("mid_hold", 32'(dac_code), 32'(saved));
    wb_read(3'd3, d);
    check("mid_flush", d, 32'h100);
    repeat (4) @(posedge clk);
    #1;
    wb_read(3'd3, d);
    check("mid_underrun", d, 32'h500);

    // Random traffic
    wb_write(3'd1, 32'd2);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 10);
      if (r <= 3) wb_write(3'd0, $urandom);
      else if (r == 4) wb_read(3'($urandom_range(0, 7)), d);
      else if (r == 5) wb_write(3'd2, 32'($urandom_range(0, 4)));
      else if (r == 6)
        wb_write(3'd1, 32'($urandom_range(0, 1)) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0));
      else if (r == 7) wb_write(3'd3, $urandom & 32'hC00);
      else if (r == 8) wb_write(3'($urandom_range(4, 5)), 32'($urandom_range(0, 3)));
      else if (r == 9) wb_read(3'd3, d);
      else repeat ($urandom_range(1, 6)) @(posedge clk);
      #0;
    end
    @(posedge clk); #1;

    // Reset during an access aborts it
    cyc = 1; stb = 1; we = 1; adr = 32'h0; dat = 32'h55; rst = 1;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; rst = 0;
    check("rst_abort_ack", 32'(ack_o), 32'd0);
    check("rst_abort_code", 32'(dac_code), 32'h80);
    wb_read(3'd3, d);
    check("rst_abort_status", d, 32'h100);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
